// File: rtl/dmem_pipe.sv
// dmem_pipe: pipelined single-port data memory with valid/ready requests, byte enables,
// out-of-range detection, configurable read latency and an optional post-reset clear sweep.
module dmem_pipe #(
    parameter int n              = 16,
    parameter int r              = 8,
    parameter int LAT            = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic [n-1:0]   req_addr,
    input  logic [n-1:0]   req_wdata,
    input  logic [n/8-1:0] req_be,
    output logic           rsp_valid,
    output logic [n-1:0]   rsp_rdata,
    output logic           rsp_err,
    output logic           busy
);
    localparam int NB    = n / 8;
    localparam int DEPTH = 2 ** r;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    localparam logic [r:0] CNT_LAST = (r + 1)'(DEPTH - 1);
    localparam logic [r:0] CNT_ONE  = (r + 1)'(1);

    logic [n-1:0] mem [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [r:0]            cnt_q, cnt_d;
    logic [LAT-1:0]        vld_q, vld_d;
    logic [LAT-1:0]        err_q, err_d;
    logic [LAT-1:0][n-1:0] dat_q, dat_d;

    logic         accept;
    logic         in_range;
    logic [r-1:0] idx;
    logic         wr_en;
    logic [r-1:0] wr_addr;
    logic [n-1:0] wr_data;
    logic [NB-1:0] wr_be;

    assign idx       = req_addr[r-1:0];
    assign in_range  = (req_addr >> r) == '0;
    assign req_ready = (state_q == ST_READY);
    assign busy      = (state_q == ST_CLEAR);
    assign accept    = req_valid && req_ready;

    // The sweep and request writes share the single array write port.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = idx;
        wr_data = req_wdata;
        wr_be   = req_be;
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q[r-1:0];
            wr_data = '0;
            wr_be   = '1;
            cnt_d   = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
                state_d = ST_READY;
            end
        end else if (accept && req_write && in_range) begin
            wr_en = 1'b1;
        end
    end

    // Stage 0 captures the response at the accepting edge; later stages just delay it.
    always_comb begin
        vld_d    = '0;
        err_d    = '0;
        dat_d    = '0;
        vld_d[0] = accept;
        err_d[0] = accept && !in_range;
        dat_d[0] = (accept && !req_write && in_range) ? mem[idx] : '0;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    // NOTE: the array itself is never reset; the clear sweep zeroes it when enabled.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = vld_q[LAT-1];
    assign rsp_err   = err_q[LAT-1];
    assign rsp_rdata = dat_q[LAT-1];

endmodule

// File: doc/dmem_pipe.md
# dmem_pipe

Parametrised, pipelined single-port data memory for the 16-bit RISC datapath. It replaces the combinational-read data segment. It adds:
- a valid/ready request handshake
- a configurable registered read latency
- per-byte write enables
- out-of-range address detection
- an optional hardware sweep that zeroes the whole array after reset

It sits between the load/store stage and the data RAM array.

## Interface
Parameters:
- n, 16, data/register width in bits; must be a multiple of 8
- r, 8, address bits actually decoded; depth = 2**r words
- LAT, 1, read/response latency in cycles; legal range 1..4
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents undefined after reset

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  n  word address
- req_wdata  in  n  write data
- req_be  in  n/8  byte enables; bit i covers bits [8i+7:8i]
- rsp_valid  out  1  response present (one-cycle pulse per request)
- rsp_rdata  out  n  read data; 0 for writes and errors
- rsp_err  out  1  request addressed outside the array
- busy  out  1  clear sweep in progress

## Operation
- **States:** CLEAR and READY.
- **Reset:**
  - Reset sets the state to CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - Reset zeroes the sweep counter and flushes the response pipeline.
- **CLEAR state:**
  - Each cycle writes 0 to word[counter], then increments the counter.
  - After word 2**r-1 is written, the next state is READY.
  - busy=1 and req_ready=0 throughout.
- **READY state:**
  - req_ready=1 and busy=0.
  - The block stays in READY until reset.
- **Acceptance:**
  - A request is accepted on a posedge where req_valid && req_ready.
  - While req_ready=0, requests have no side effect; the requester holds them.
- **Range check:**
  - A request is in range when req_addr[n-1:r] == 0.
  - Out of range: no array write; the response carries rsp_err=1 and rsp_rdata=0.
- **Write:**
  - An in-range write updates only the bytes whose req_be bit is 1, at the accepting edge.
  - req_be=0 is a legal no-op write that still produces a response.
  - The response has rsp_rdata=0 and rsp_err=0.
- **Read:**
  - Returns word[addr] as it stands after all earlier accepted writes.
  - A write accepted at edge k is visible to a read accepted at edge k+1.
- **Ordering and throughput:**
  - Exactly one response per accepted request, strictly in acceptance order.
  - No response backpressure; one request per cycle is sustained.

## Timing
- **Output values during reset and sweep:** rsp_valid=0, rsp_rdata=0, rsp_err=0.
- **During the sweep:** busy=1 and req_ready=0.
- **CLEAR_ON_RESET=1:**
  - The first cycle with reset low clears word 0.
  - req_ready rises 2**r cycles after reset deasserts (256 cycles at r=8).
- **CLEAR_ON_RESET=0:** req_ready=1 in the first cycle after reset deasserts.
- **Response latency:** a request accepted at edge E0 gives rsp_valid=1 for exactly the one cycle following edge E0+LAT-1. With LAT=1 the response is visible in the cycle right after acceptance.
- **Outputs with no response:** when rsp_valid=0, rsp_rdata=0 and rsp_err=0.
- **Pipeline stages:** LAT-1 extra stages delay valid, err and data together; there are no bubbles on back-to-back requests.
- **Reset mid-operation:**
  - In-flight responses are discarded; rsp_valid=0 from the next cycle.
  - The sweep restarts at word 0.
  - An array write accepted at the same edge reset is sampled high is not performed.
- **Wrap-around:** the sweep counter is r+1 bits wide, so the terminal count is detected without wrap.

## Test plan
- **Reset sweep:** reset for 2 cycles with r=8, CLEAR_ON_RESET=1. Require busy=1 and req_ready=0 for 256 cycles, then req_ready=1. Reads of addr 0, 127 and 255 then return 0x0000.
- **Byte enables:** write 0xABCD to addr 5 with be=11, then write 0x1234 to addr 5 with be=01. A read of addr 5 returns 0xAB34. A write with be=00 leaves 0xAB34.
- **Back-to-back, LAT=3:**
  - Write addr 9 = 0xBEEF, then read addr 9 on the next cycle, then read addr 10 (never written, so 0).
  - Responses arrive 3 cycles after each acceptance in consecutive cycles: write (0x0000), 0xBEEF, 0x0000.
- **Out of range:** write 0x5555 to addr 0x0100 with r=8. The response has rsp_err=1 and rsp_rdata=0. A following read of addr 0x00 still returns 0, since the address did not alias.
- **Reset mid-operation:** issue 3 reads with LAT=2, then assert reset for 1 cycle while 2 responses are in flight. No rsp_valid appears after reset, and busy=1 from the cycle after reset.
- **Handshake stall:** hold req_valid=1 with a write during the sweep. No memory change occurs until req_ready=1, and exactly one response follows LAT cycles after acceptance.
